// File: rtl/rf_ch_mc_ctl.sv
`default_nettype none
// ============================================================================
// Module   : rf_ch_mc_ctl
// Purpose  : Multi-channel RF front-end controller. A single command port
//            drives CH_NUM receive channels. Each command:
//              - sets the AMP1/AMP2 through/bypass switches of one channel
//              - writes a clamped 6-bit ADL5201 gain code over a shared
//                3-wire, write-only SPI frame {GAIN_ADDR, 2'b00, gain}
//              - pulses that channel's gain latch
// Ports    : CLK, nRST (async, active low)
//            CMD_VALID/CMD_READY handshake with CMD_CH, CMD_GAIN, CMD_PATH
//            PWR_EN          per-channel power enable -> CH_5201_PM (1 flop)
//            BUSY, DONE, ERR, CLAMP status
//            CH_AMP{1,2}_{THR,BYPASS}  per-channel switch controls
//            CH_5201_CS (active low), CH_5201_SCLK, CH_5201_SDIO,
//            CH_5201_LATCH (active high)
// Config   : `define RF_CH_MC_BBM_EN enables break-before-make dead time
//            (DEAD_CYC cycles) on any amplifier whose path changes.
// Revision : 1.0  initial release
// ============================================================================
module rf_ch_mc_ctl #(
  parameter int         CH_NUM    = 4,
  parameter int         CH_W      = 2,
  parameter int         CLK_DIV   = 4,
  parameter logic [5:0] GAIN_MAX  = 6'd60,
  parameter logic [7:0] GAIN_ADDR = 8'h00,
  parameter int         DEAD_CYC  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [CH_W-1:0]   CMD_CH,
  input  logic [5:0]        CMD_GAIN,
  input  logic [1:0]        CMD_PATH,
  input  logic [CH_NUM-1:0] PWR_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              CLAMP,
  output logic [CH_NUM-1:0] CH_AMP1_THR,
  output logic [CH_NUM-1:0] CH_AMP1_BYPASS,
  output logic [CH_NUM-1:0] CH_AMP2_THR,
  output logic [CH_NUM-1:0] CH_AMP2_BYPASS,
  output logic [CH_NUM-1:0] CH_5201_CS,
  output logic              CH_5201_SCLK,
  output logic              CH_5201_SDIO,
  output logic [CH_NUM-1:0] CH_5201_PM,
  output logic [CH_NUM-1:0] CH_5201_LATCH
);

  // Counter is shared by every timed phase, so size it for the longest one.
  localparam int c_cnt_max = (2 * CLK_DIV > DEAD_CYC) ? 2 * CLK_DIV : DEAD_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_div_m1 = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_bit_m1 = c_cnt_w'(2 * CLK_DIV - 1);
`ifdef RF_CH_MC_BBM_EN
  localparam logic [c_cnt_w-1:0] c_dead_m1 = c_cnt_w'(DEAD_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PATH     = 3'd1,
    S_CS_SETUP = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_HOLD  = 3'd4,
    S_LATCH    = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [15:0]          sh_q, sh_d;
  logic [CH_NUM-1:0]    sel_q, sel_d;        // one-hot selected channel
  logic                 clamp_flag_q, clamp_flag_d;
`ifdef RF_CH_MC_BBM_EN
  logic [1:0]           path_q, path_d;
`endif
  logic [CH_NUM-1:0]    thr1_q, thr1_d, byp1_q, byp1_d;
  logic [CH_NUM-1:0]    thr2_q, thr2_d, byp2_q, byp2_d;
  logic [CH_NUM-1:0]    cs_q, cs_d, latch_q, latch_d, pm_q;
  logic                 sclk_q, sclk_d, sdio_q, sdio_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 err_q, err_d, clamp_q, clamp_d;

  logic [CH_NUM-1:0]    w_cmd_sel;
  logic                 w_ch_bad;
  logic                 w_accept;
  logic                 w_clamp;
  logic [5:0]           w_gain;
  logic [15:0]          w_frame;
`ifdef RF_CH_MC_BBM_EN
  logic                 w_chg1, w_chg2;
`endif

  // Replace the selected channel's bits of a per-channel vector with val.
  function automatic logic [CH_NUM-1:0] f_set(input logic [CH_NUM-1:0] cur,
                                              input logic [CH_NUM-1:0] sel,
                                              input logic              val);
    return (cur & ~sel) | (sel & {CH_NUM{val}});
  endfunction

  always_comb begin
    w_cmd_sel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_cmd_sel[i] = (32'(CMD_CH) == 32'(i));
    end
  end

  assign w_ch_bad  = (32'(CMD_CH) >= 32'(CH_NUM));
  assign w_accept  = CMD_VALID & ~busy_q;
  assign w_clamp   = (CMD_GAIN > GAIN_MAX);
  assign w_gain    = w_clamp ? GAIN_MAX : CMD_GAIN;
  assign w_frame   = {GAIN_ADDR, 2'b00, w_gain};
`ifdef RF_CH_MC_BBM_EN
  assign w_chg1    = (|(thr1_q & w_cmd_sel)) != CMD_PATH[0];
  assign w_chg2    = (|(thr2_q & w_cmd_sel)) != CMD_PATH[1];
`endif

  // All pin-facing outputs are registered; next values are computed here
  // together with the state so every pin changes on a clock edge only.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    sel_d        = sel_q;
    clamp_flag_d = clamp_flag_q;
`ifdef RF_CH_MC_BBM_EN
    path_d       = path_q;
`endif
    thr1_d       = thr1_q;
    byp1_d       = byp1_q;
    thr2_d       = thr2_q;
    byp2_d       = byp2_q;
    cs_d         = cs_q;
    latch_d      = latch_q;
    sclk_d       = sclk_q;
    sdio_d       = sdio_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    clamp_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_ch_bad) begin
            err_d = 1'b1;
          end else begin
            sel_d        = w_cmd_sel;
            clamp_flag_d = w_clamp;
            sh_d         = w_frame;
            cnt_d        = '0;
            bit_d        = '0;
`ifdef RF_CH_MC_BBM_EN
            path_d = CMD_PATH;
            if (w_chg1 || w_chg2) begin
              // Open only the amplifiers that change; the other keeps its state.
              state_d = S_PATH;
              if (w_chg1) begin
                thr1_d = thr1_q & ~w_cmd_sel;
                byp1_d = byp1_q & ~w_cmd_sel;
              end
              if (w_chg2) begin
                thr2_d = thr2_q & ~w_cmd_sel;
                byp2_d = byp2_q & ~w_cmd_sel;
              end
            end else begin
              state_d = S_CS_SETUP;
              cs_d    = cs_q & ~w_cmd_sel;
              sdio_d  = w_frame[15];
            end
`else
            // The path is applied on the accept edge, so the PATH state
            // takes no cycles here and CS falls together with the switches.
            thr1_d  = f_set(thr1_q, w_cmd_sel, CMD_PATH[0]);
            byp1_d  = f_set(byp1_q, w_cmd_sel, ~CMD_PATH[0]);
            thr2_d  = f_set(thr2_q, w_cmd_sel, CMD_PATH[1]);
            byp2_d  = f_set(byp2_q, w_cmd_sel, ~CMD_PATH[1]);
            state_d = S_CS_SETUP;
            cs_d    = cs_q & ~w_cmd_sel;
            sdio_d  = w_frame[15];
`endif
          end
        end
      end

`ifdef RF_CH_MC_BBM_EN
      S_PATH: begin
        if (cnt_q == c_dead_m1) begin
          thr1_d  = f_set(thr1_q, sel_q, path_q[0]);
          byp1_d  = f_set(byp1_q, sel_q, ~path_q[0]);
          thr2_d  = f_set(thr2_q, sel_q, path_q[1]);
          byp2_d  = f_set(byp2_q, sel_q, ~path_q[1]);
          cs_d    = cs_q & ~sel_q;
          sdio_d  = sh_q[15];
          cnt_d   = '0;
          state_d = S_CS_SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_CS_SETUP: begin
        if (cnt_q == c_div_m1) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == c_bit_m1) begin
          // Bit boundary: SCLK falls and the next bit is presented.
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = S_CS_HOLD;
          end else begin
            bit_d  = bit_q + 4'd1;
            sh_d   = {sh_q[14:0], 1'b0};
            sdio_d = sh_q[14];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == c_div_m1) begin
            sclk_d = 1'b1;
          end
        end
      end

      S_CS_HOLD: begin
        if (cnt_q == c_div_m1) begin
          cs_d    = '1;
          sdio_d  = 1'b0;
          latch_d = sel_q;
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_LATCH: begin
        if (cnt_q == c_div_m1) begin
          latch_d = '0;
          done_d  = 1'b1;
          clamp_d = clamp_flag_q;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      sel_q        <= '0;
      clamp_flag_q <= 1'b0;
`ifdef RF_CH_MC_BBM_EN
      path_q       <= 2'b00;
`endif
      thr1_q       <= '0;
      byp1_q       <= '1;
      thr2_q       <= '0;
      byp2_q       <= '1;
      cs_q         <= '1;
      latch_q      <= '0;
      pm_q         <= '0;
      sclk_q       <= 1'b0;
      sdio_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      clamp_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      sel_q        <= sel_d;
      clamp_flag_q <= clamp_flag_d;
`ifdef RF_CH_MC_BBM_EN
      path_q       <= path_d;
`endif
      thr1_q       <= thr1_d;
      byp1_q       <= byp1_d;
      thr2_q       <= thr2_d;
      byp2_q       <= byp2_d;
      cs_q         <= cs_d;
      latch_q      <= latch_d;
      pm_q         <= PWR_EN;
      sclk_q       <= sclk_d;
      sdio_q       <= sdio_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      clamp_q      <= clamp_d;
    end
  end

  assign CMD_READY      = ~busy_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR            = err_q;
  assign CLAMP          = clamp_q;
  assign CH_AMP1_THR    = thr1_q;
  assign CH_AMP1_BYPASS = byp1_q;
  assign CH_AMP2_THR    = thr2_q;
  assign CH_AMP2_BYPASS = byp2_q;
  assign CH_5201_CS     = cs_q;
  assign CH_5201_SCLK   = sclk_q;
  assign CH_5201_SDIO   = sdio_q;
  assign CH_5201_PM     = pm_q;
  assign CH_5201_LATCH  = latch_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_ch_mc_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_ch_mc_ctl
// Purpose  : Directed self-checking bench for rf_ch_mc_ctl (CH_NUM=4,
//            CH_W=3, CLK_DIV=4, DEAD_CYC=16). Expected timing shifts by
//            DEAD_CYC on path changes when RF_CH_MC_BBM_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_ch_mc_ctl;

`ifdef RF_CH_MC_BBM_EN
  localparam int BBM_DLY = 16;
`else
  localparam int BBM_DLY = 0;
`endif

  logic       CLK, nRST, CMD_VALID, CMD_READY;
  logic [2:0] CMD_CH;
  logic [5:0] CMD_GAIN;
  logic [1:0] CMD_PATH;
  logic [3:0] PWR_EN;
  logic       BUSY, DONE, ERR, CLAMP;
  logic [3:0] CH_AMP1_THR, CH_AMP1_BYPASS, CH_AMP2_THR, CH_AMP2_BYPASS;
  logic [3:0] CH_5201_CS, CH_5201_PM, CH_5201_LATCH;
  logic       CH_5201_SCLK, CH_5201_SDIO;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observation results of one transaction
  int          obs_done, obs_cs_low, obs_cs_first, obs_latch, obs_other, obs_dead, obs_both1;
  logic        obs_clamp;
  logic [15:0] obs_frame;
  logic [3:0]  k1_thr1, k1_byp1, k1_thr2, k1_byp2, k1_cs;
  logic        k1_busy;

  rf_ch_mc_ctl #(
    .CH_NUM(4), .CH_W(3), .CLK_DIV(4), .GAIN_MAX(6'd60), .GAIN_ADDR(8'h00), .DEAD_CYC(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_CH(CMD_CH), .CMD_GAIN(CMD_GAIN), .CMD_PATH(CMD_PATH), .PWR_EN(PWR_EN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CLAMP(CLAMP),
    .CH_AMP1_THR(CH_AMP1_THR), .CH_AMP1_BYPASS(CH_AMP1_BYPASS),
    .CH_AMP2_THR(CH_AMP2_THR), .CH_AMP2_BYPASS(CH_AMP2_BYPASS),
    .CH_5201_CS(CH_5201_CS), .CH_5201_SCLK(CH_5201_SCLK), .CH_5201_SDIO(CH_5201_SDIO),
    .CH_5201_PM(CH_5201_PM), .CH_5201_LATCH(CH_5201_LATCH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept happens on the posedge inside this task (cycle T0).
  task automatic send_cmd(input logic [2:0] ch, input logic [5:0] gain, input logic [1:0] path);
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_CH = ch; CMD_GAIN = gain; CMD_PATH = path;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  // Samples cycles T0+1.. at negedges until DONE or limit; collects only.
  task automatic observe(input int ch, input int limit);
    logic prev_sclk;
    prev_sclk = 1'b0;
    obs_done = -1; obs_cs_low = 0; obs_cs_first = -1; obs_latch = 0;
    obs_other = 0; obs_dead = 0; obs_both1 = 0; obs_clamp = 1'b0; obs_frame = '0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        k1_thr1 = CH_AMP1_THR; k1_byp1 = CH_AMP1_BYPASS;
        k1_thr2 = CH_AMP2_THR; k1_byp2 = CH_AMP2_BYPASS;
        k1_cs = CH_5201_CS; k1_busy = BUSY;
      end
      if (!CH_5201_CS[ch]) begin
        obs_cs_low++;
        if (obs_cs_first < 0) obs_cs_first = k;
      end
      if (CH_5201_LATCH[ch]) obs_latch++;
      for (int i = 0; i < 4; i++)
        if (i != ch && (!CH_5201_CS[i] || CH_5201_LATCH[i])) obs_other++;
      if ((!CH_AMP1_THR[ch] && !CH_AMP1_BYPASS[ch]) || (!CH_AMP2_THR[ch] && !CH_AMP2_BYPASS[ch]))
        obs_dead++;
      if (((CH_AMP1_THR & CH_AMP1_BYPASS) | (CH_AMP2_THR & CH_AMP2_BYPASS)) != 4'b0000)
        obs_both1++;
      if (!prev_sclk && CH_5201_SCLK) obs_frame = {obs_frame[14:0], CH_5201_SDIO};
      prev_sclk = CH_5201_SCLK;
      if (DONE) begin
        obs_done = k; obs_clamp = CLAMP;
        break;
      end
    end
  endtask

  task automatic test_reset;
    CMD_VALID = 1'b0; CMD_CH = '0; CMD_GAIN = '0; CMD_PATH = '0; PWR_EN = 4'b0000;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    tests_run++;
    if ({CH_AMP1_THR, CH_AMP2_THR} !== 8'h00) begin
      tests_failed++; $display("FAIL reset_thr: got %h expected 00", {CH_AMP1_THR, CH_AMP2_THR});
    end
    tests_run++;
    if ({CH_AMP1_BYPASS, CH_AMP2_BYPASS} !== 8'hFF) begin
      tests_failed++; $display("FAIL reset_byp: got %h expected ff", {CH_AMP1_BYPASS, CH_AMP2_BYPASS});
    end
    tests_run++;
    if ({CH_5201_CS, CH_5201_LATCH, CH_5201_PM} !== 12'hF00) begin
      tests_failed++; $display("FAIL reset_cs_latch_pm: got %h expected f00", {CH_5201_CS, CH_5201_LATCH, CH_5201_PM});
    end
    tests_run++;
    if ({CH_5201_SCLK, CH_5201_SDIO, BUSY, DONE, ERR, CLAMP, CMD_READY} !== 7'b0000001) begin
      tests_failed++; $display("FAIL reset_status: got %b expected 0000001",
        {CH_5201_SCLK, CH_5201_SDIO, BUSY, DONE, ERR, CLAMP, CMD_READY});
    end
    PWR_EN = 4'b0101;
    @(negedge CLK);
    tests_run++;
    if (CH_5201_PM !== 4'b0101) begin
      tests_failed++; $display("FAIL pm_follow: got %b expected 0101", CH_5201_PM);
    end
  endtask

  task automatic test_normal;
    send_cmd(3'd2, 6'd21, 2'b01);
    observe(2, 400);
    tests_run++;
    if (k1_thr1 !== ((BBM_DLY > 0) ? 4'b0000 : 4'b0100) || k1_byp1 !== 4'b1011) begin
      tests_failed++; $display("FAIL normal_amp1_t1: got thr %b byp %b", k1_thr1, k1_byp1);
    end
    tests_run++;
    if (k1_thr2 !== 4'b0000 || k1_byp2 !== 4'b1111) begin
      tests_failed++; $display("FAIL normal_amp2_t1: got thr %b byp %b expected 0000/1111", k1_thr2, k1_byp2);
    end
    tests_run++;
    if (k1_cs !== ((BBM_DLY > 0) ? 4'b1111 : 4'b1011) || k1_busy !== 1'b1) begin
      tests_failed++; $display("FAIL normal_cs_busy_t1: got cs %b busy %b", k1_cs, k1_busy);
    end
    tests_run++;
    if (obs_frame !== 16'h0015) begin
      tests_failed++; $display("FAIL normal_frame: got %h expected 0015", obs_frame);
    end
    tests_run++;
    if (obs_cs_low != 136 || obs_latch != 4 || obs_other != 0) begin
      tests_failed++; $display("FAIL normal_cs_latch: got cs_low %0d latch %0d other %0d expected 136 4 0",
        obs_cs_low, obs_latch, obs_other);
    end
    tests_run++;
    if (obs_done != 141 + BBM_DLY || obs_clamp !== 1'b0) begin
      tests_failed++; $display("FAIL normal_done: got cycle %0d clamp %b expected %0d 0", obs_done, obs_clamp, 141 + BBM_DLY);
    end
    tests_run++;
    if (CH_AMP1_THR !== 4'b0100 || CH_AMP2_BYPASS !== 4'b1111) begin
      tests_failed++; $display("FAIL normal_final_sw: got thr1 %b byp2 %b expected 0100 1111", CH_AMP1_THR, CH_AMP2_BYPASS);
    end
    tests_run++;
    if (CMD_READY !== 1'b0) begin
      tests_failed++; $display("FAIL normal_ready_at_done: got %b expected 0", CMD_READY);
    end
    @(negedge CLK);
    tests_run++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++; $display("FAIL normal_ready_after: got ready %b busy %b expected 1 0", CMD_READY, BUSY);
    end
  endtask

  task automatic test_clamp;
    send_cmd(3'd1, 6'd63, 2'b10);
    observe(1, 400);
    tests_run++;
    if (obs_frame !== 16'h003C) begin
      tests_failed++; $display("FAIL clamp_frame: got %h expected 003c", obs_frame);
    end
    tests_run++;
    if (obs_done != 141 + BBM_DLY || obs_clamp !== 1'b1) begin
      tests_failed++; $display("FAIL clamp_pulse: got cycle %0d clamp %b expected %0d 1", obs_done, obs_clamp, 141 + BBM_DLY);
    end
    tests_run++;
    if ({CH_AMP1_THR, CH_AMP1_BYPASS, CH_AMP2_THR, CH_AMP2_BYPASS} !== 16'b0100_1011_0010_1101) begin
      tests_failed++; $display("FAIL clamp_switches: got %b expected 0100101100101101",
        {CH_AMP1_THR, CH_AMP1_BYPASS, CH_AMP2_THR, CH_AMP2_BYPASS});
    end
    @(negedge CLK);
    tests_run++;
    if (CLAMP !== 1'b0) begin
      tests_failed++; $display("FAIL clamp_width: got %b expected 0", CLAMP);
    end
  endtask

  task automatic test_bad_channel;
    int cs_act;
    cs_act = 0;
    send_cmd(3'd5, 6'd10, 2'b11);
    @(negedge CLK);
    tests_run++;
    if (ERR !== 1'b1 || CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++; $display("FAIL bad_err_t1: got err %b ready %b busy %b expected 1 1 0", ERR, CMD_READY, BUSY);
    end
    for (int k = 2; k <= 12; k++) begin
      @(negedge CLK);
      if (CH_5201_CS !== 4'b1111 || ERR !== 1'b0) cs_act++;
    end
    tests_run++;
    if (cs_act != 0) begin
      tests_failed++; $display("FAIL bad_no_activity: got %0d active cycles expected 0", cs_act);
    end
    tests_run++;
    if ({CH_AMP1_THR, CH_AMP2_THR} !== 8'b0100_0010) begin
      tests_failed++; $display("FAIL bad_switches: got %b expected 01000010", {CH_AMP1_THR, CH_AMP2_THR});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_CH = 3'd0; CMD_GAIN = 6'd5; CMD_PATH = 2'b11;
    @(posedge CLK);
    #1 CMD_CH = 3'd3; CMD_GAIN = 6'd7; CMD_PATH = 2'b00;
    observe(0, 400);
    tests_run++;
    if (obs_done != 141 + BBM_DLY || obs_other != 0 || CMD_READY !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_first: got done %0d other %0d ready %b expected %0d 0 0",
        obs_done, obs_other, CMD_READY, 141 + BBM_DLY);
    end
    @(negedge CLK);
    tests_run++;
    if (CMD_READY !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_ready: got %b expected 1", CMD_READY);
    end
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    observe(3, 400);
    tests_run++;
    if (obs_cs_first != 1 || obs_done != 141 || obs_frame !== 16'h0007) begin
      tests_failed++; $display("FAIL b2b_second: got cs_first %0d done %0d frame %h expected 1 141 0007",
        obs_cs_first, obs_done, obs_frame);
    end
    tests_run++;
    if ({CH_AMP1_THR, CH_AMP2_THR, CH_AMP1_BYPASS, CH_AMP2_BYPASS} !== 16'b0101_0011_1010_1100) begin
      tests_failed++; $display("FAIL b2b_switches: got %b expected 0101001110101100",
        {CH_AMP1_THR, CH_AMP2_THR, CH_AMP1_BYPASS, CH_AMP2_BYPASS});
    end
  endtask

  task automatic test_reset_mid;
    send_cmd(3'd1, 6'd40, 2'b11);
    repeat (50 + BBM_DLY) @(negedge CLK);
    tests_run++;
    if (CH_5201_CS !== 4'b1101 || BUSY !== 1'b1) begin
      tests_failed++; $display("FAIL mid_busy: got cs %b busy %b expected 1101 1", CH_5201_CS, BUSY);
    end
    nRST = 1'b0;
    #1;
    tests_run++;
    if (CH_5201_CS !== 4'b1111 || CH_5201_SCLK !== 1'b0 || CH_5201_LATCH !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_rst_spi: got cs %b sclk %b latch %b expected 1111 0 0000",
        CH_5201_CS, CH_5201_SCLK, CH_5201_LATCH);
    end
    tests_run++;
    if ({CH_AMP1_THR, CH_AMP2_THR, CH_AMP1_BYPASS, CH_AMP2_BYPASS} !== 16'h00FF) begin
      tests_failed++; $display("FAIL mid_rst_bypass: got %h expected 00ff",
        {CH_AMP1_THR, CH_AMP2_THR, CH_AMP1_BYPASS, CH_AMP2_BYPASS});
    end
    tests_run++;
    if (BUSY !== 1'b0 || CMD_READY !== 1'b1 || CH_5201_PM !== 4'b0000) begin
      tests_failed++; $display("FAIL mid_rst_status: got busy %b ready %b pm %b expected 0 1 0000",
        BUSY, CMD_READY, CH_5201_PM);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_path_change;
    send_cmd(3'd3, 6'd12, 2'b01);
    observe(3, 400);
    tests_run++;
    if (obs_dead != BBM_DLY || obs_both1 != 0) begin
      tests_failed++; $display("FAIL path_dead: got dead %0d both1 %0d expected %0d 0", obs_dead, obs_both1, BBM_DLY);
    end
    tests_run++;
    if (obs_cs_first != 1 + BBM_DLY || obs_done != 141 + BBM_DLY || obs_frame !== 16'h000C) begin
      tests_failed++; $display("FAIL path_timing: got cs_first %0d done %0d frame %h expected %0d %0d 000c",
        obs_cs_first, obs_done, obs_frame, 1 + BBM_DLY, 141 + BBM_DLY);
    end
    tests_run++;
    if (CH_AMP1_THR[3] !== 1'b1 || CH_AMP1_BYPASS[3] !== 1'b0) begin
      tests_failed++; $display("FAIL path_state: got thr %b byp %b expected 1 0", CH_AMP1_THR[3], CH_AMP1_BYPASS[3]);
    end
    send_cmd(3'd3, 6'd12, 2'b01);
    observe(3, 400);
    tests_run++;
    if (obs_dead != 0 || obs_done != 141) begin
      tests_failed++; $display("FAIL path_repeat: got dead %0d done %0d expected 0 141", obs_dead, obs_done);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_clamp;
    test_bad_channel;
    test_back_to_back;
    test_reset_mid;
    test_path_change;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
